// File: rtl/piso_serializer.sv
// piso_serializer: WIDTH-bit word to MSB-first serial frame with frame-valid strobe; `PISO_PARITY_EN adds an even parity bit.
// Latency: first bit one cycle after load accept; one word per WIDTH+2 cycles (WIDTH+3 with parity).
// Backpressure: load_ready low from accept until the cycle after done; load_valid/d_in ignored meanwhile.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("piso_serializer: WIDTH must be 1..32");
    end
  endgenerate

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             load_acc;
  logic             ser_out_nxt, ser_valid_nxt, busy_nxt, done_nxt;
`ifdef PISO_PARITY_EN
  logic             par_q, par_nxt;
`endif

  assign load_ready = (state == IDLE) && !reset;
  assign load_acc   = load_valid && load_ready;

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
`ifdef PISO_PARITY_EN
    par_nxt   = par_q;
`endif
    case (state)
      IDLE: begin
        if (load_acc) begin
          shreg_nxt = d_in;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
          par_nxt   = ^d_in;
`endif
        end
      end
      SHIFT: begin
        shreg_nxt = shreg << 1;
        // Counter holds at zero; the frame exits from the last bit instead of wrapping.
        if (cnt == '0) begin
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = DONE;
`endif
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    ser_out_nxt   = 1'b0;
    ser_valid_nxt = 1'b0;
    if (state_nxt == SHIFT) begin
      ser_out_nxt   = shreg_nxt[WIDTH-1];
      ser_valid_nxt = 1'b1;
    end
`ifdef PISO_PARITY_EN
    if (state_nxt == PARITY) begin
      ser_out_nxt   = par_nxt;
      ser_valid_nxt = 1'b1;
    end
`endif
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      ser_out   <= ser_out_nxt;
      ser_valid <= ser_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
`ifdef PISO_PARITY_EN
      par_q     <= par_nxt;
`endif
    end
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that converts a `WIDTH`-bit word into an MSB-first bit stream with a frame-valid strobe. It is the transmit-side counterpart to the flip-flop/shift-register capture stages in the lab set. It sits between a parallel producer, which uses a valid/ready load handshake, and a serial link whose receiver samples `ser_out` on every clock where `ser_valid` is high.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 1 to 32.
- `clock`  input  1  single clock; all state updates on the posedge.
- `reset`  input  1  reset is synchronous and active-high.
- `d_in`  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
- `load_valid`  input  1  producer offers `d_in`.
- `load_ready`  output  1  block can accept a word; combinational from state, forced 0 while `reset` is high.
- `ser_out`  output  1  serial data bit (registered).
- `ser_valid`  output  1  `ser_out` carries a frame bit this cycle (registered).
- `busy`  output  1  a frame is in progress: SHIFT, PARITY or DONE (registered).
- `done`  output  1  one-cycle pulse after the last frame bit (registered).

## Operation
- FSM states: IDLE, SHIFT, PARITY (only with the macro defined), DONE.
- **IDLE**
  - `load_ready` = 1.
  - A load is accepted when `load_valid` and `load_ready` are both high at a posedge.
  - On an accepted load: capture `d_in` into the shift register, set the bit counter to `WIDTH-1`, go to SHIFT.
- **SHIFT**
  - `ser_out` = shift register MSB, `ser_valid` = 1.
  - Each cycle: shift left by 1 and decrement the counter.
  - When the counter is 0: go to PARITY if enabled, otherwise go to DONE.
- **PARITY**: one cycle with `ser_out` = even parity of the captured word (XOR of all bits) and `ser_valid` = 1; then go to DONE.
- **DONE**: one cycle with `done` = 1, `ser_valid` = 0, `ser_out` = 0; then go to IDLE.
- **Outputs outside frame bits:** `ser_out` = 0 and `ser_valid` = 0.
- **Counter:** $clog2(WIDTH) bits, minimum 1. It never wraps: exit happens at 0.
- **Loads while not in IDLE:** `load_ready` is 0, `load_valid` is ignored and `d_in` is not sampled. The producer must hold `load_valid` until accepted.
- **`d_in` after capture:** changes have no effect on the frame in flight.
- **`WIDTH` = 1:** SHIFT lasts exactly one cycle.

## Timing
- **Reset values:** state IDLE, `ser_out` 0, `ser_valid` 0, `busy` 0, `done` 0, shift register and counter 0.
- **`load_ready` during reset:** 0 while `reset` is high; 1 in the first cycle after `reset` falls.
- **Reset mid-frame:** aborts the frame. All outputs take their reset values after that posedge. No `done` pulse is produced.
- **Load accepted at posedge k:**
  - Bit `WIDTH-1` appears on `ser_out` with `ser_valid` high in cycle k+1.
  - Bit 0 appears in cycle k+WIDTH.
  - Parity, if enabled, appears in cycle k+WIDTH+1.
  - `done` is high in the next cycle.
  - `load_ready` returns high in the cycle after `done`.
- **Throughput:** one word per WIDTH+2 cycles, or WIDTH+3 with parity. There are no back-to-back frames without the DONE gap.
- **`busy`:** high exactly from cycle k+1 through the `done` cycle inclusive.
- **Reset vs. `load_valid`:** `reset` and `load_valid` high together means reset wins and no load is accepted.

## Configuration
- `PISO_PARITY_EN`, defined:
  - PARITY state is compiled in.
  - The frame is WIDTH+1 valid bits, ending with the even parity bit.
- `PISO_PARITY_EN`, undefined:
  - No PARITY state and no parity logic.
  - The frame is exactly WIDTH valid bits.

## Test plan
- **Reset:** hold `reset` high 3 cycles with `load_valid`=1 and `d_in`=8'hFF. Required: no load accepted, `load_ready`=0, all outputs 0. After release, `load_ready`=1 in the next cycle.
- **Basic frame (WIDTH=8, no macro):** load 8'hA5. Required:
  - `ser_out` = 1,0,1,0,0,1,0,1 with `ser_valid`=1 for 8 cycles.
  - `done`=1 in cycle 9.
  - `load_ready`=1 in cycle 10.
- **Parity (macro defined):** load 8'h07. Required: bits 0,0,0,0,0,1,1,1, then parity bit 1 (9 valid cycles), then `done`.
- **Busy rejection:** during the 8'hA5 frame, pulse `load_valid` with `d_in`=8'h3C. Required: word not accepted, stream unchanged. Holding `load_valid` causes acceptance of 8'h3C in the cycle after `done`.
- **Reset mid-frame:** assert `reset` after the 4th bit of 8'hA5. Required: `ser_valid`, `busy`, `done` all 0 on the next cycle, and no `done` pulse. A new 8'h81 then transmits as 1,0,0,0,0,0,0,1.
- **WIDTH=1:** load 1'b1. Required: one `ser_valid` cycle with `ser_out`=1, then `done`.
